// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_t;

    // x0 is hardwired to zero, so it is never a forwarding or hazard source.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// Execute-stage operand forwarding select for one source register.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rd_m,
    input  logic [WIDTH-1:0] rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    output logic [1:0]       sel
);

    // NOTE: assigning a default before the if-chain keeps this purely combinational (no latch).
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && rd_m != WIDTH'(REG_ZERO) && rd_m == rs)
            sel = FWD_M;
        else if (reg_write_w && rd_w != WIDTH'(REG_ZERO) && rd_w == rs)
            sel = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage RV32I core, with memory-wait
// tracking, a sticky watchdog and saturating performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     Rs1D,
    input  logic [WIDTH-1:0]     Rs2D,
    input  logic [WIDTH-1:0]     Rs1E,
    input  logic [WIDTH-1:0]     Rs2E,
    input  logic [WIDTH-1:0]     RdE,
    input  logic [WIDTH-1:0]     RdM,
    input  logic [WIDTH-1:0]     RdW,
    input  logic                 MemReadE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic [CNT_WIDTH-1:0] StallCycles,
    output logic [CNT_WIDTH-1:0] FlushCount,
    output logic                 MemTimeout
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    hz_state_t       state;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_wait;
    logic            load_use;
    logic            branch_flush;

    fwd_unit #(.WIDTH(WIDTH)) u_fwd_a (
        .rs(Rs1E), .rd_m(RdM), .rd_w(RdW),
        .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .sel(ForwardAE)
    );

    fwd_unit #(.WIDTH(WIDTH)) u_fwd_b (
        .rs(Rs2E), .rd_m(RdM), .rd_w(RdW),
        .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .sel(ForwardBE)
    );

    assign mem_wait     = MemReqM && !MemReadyM;
    assign load_use     = MemReadE && RdE != WIDTH'(REG_ZERO) && (RdE == Rs1D || RdE == Rs2D);
    assign branch_flush = PCSrcE && !mem_wait;

    // A frozen pipeline defers branch and load-use: their conditions persist until release.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_wait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            StallCycles <= '0;
            FlushCount  <= '0;
            MemTimeout  <= 1'b0;
        end else begin
            if (wait_cnt == WC_MAX)
                MemTimeout <= 1'b1;

            case (state)
                RUN: begin
                    if (mem_wait) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_wait) begin
                        if (wait_cnt != WC_MAX)
                            wait_cnt <= wait_cnt + 1'b1;
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                default: state <= RUN;
            endcase

            if (StallF && StallCycles != '1)
                StallCycles <= StallCycles + 1'b1;
            if (branch_flush && FlushCount != '1)
                FlushCount <= FlushCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model pushes expected outputs
// as stimulus is applied; they are popped and compared once the outputs settle.
module tb_hazard_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [1:0] ForwardAE, ForwardBE;
    logic [31:0] StallCycles, FlushCount;

    hazard_ctrl #(.WIDTH(5), .CNT_WIDTH(32), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCycles(StallCycles), .FlushCount(FlushCount), .MemTimeout(MemTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  sf;      // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
        logic [1:0]  fa, fb;
        logic [31:0] sc, fc;
        logic        to;
        logic        st;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failed = 0;

    bit          m_state;
    int          m_cnt;
    bit          m_to;
    logic [31:0] m_stall, m_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_mw();
        return MemReqM && !MemReadyM;
    endfunction

    function automatic logic [6:0] m_ctl();
        bit lu;
        lu = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (m_mw())      return 7'b1111_001;
        else if (PCSrcE) return 7'b0000_110;
        else if (lu)     return 7'b1100_010;
        return 7'b0;
    endfunction

    task automatic m_reset();
        m_state = 0; m_cnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic m_advance();
        logic [6:0] c;
        c = m_ctl();
        if (m_cnt == TO) m_to = 1;
        if (!m_state) begin
            if (m_mw()) begin m_state = 1; m_cnt = 0; end
        end else if (m_mw()) begin
            if (m_cnt != TO) m_cnt++;
        end else begin
            m_state = 0; m_cnt = 0;
        end
        if (c[6] && m_stall != '1) m_stall++;
        if (c[2] && m_flush != '1) m_flush++;
    endtask

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic cycle();
        exp_t e;
        e.sf = m_ctl(); e.fa = m_fwd(Rs1E); e.fb = m_fwd(Rs2E);
        e.sc = m_stall; e.fc = m_flush; e.to = m_to; e.st = m_state;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check("ctl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 32'(e.sf));
        check("fwd_a", 32'(ForwardAE), 32'(e.fa));
        check("fwd_b", 32'(ForwardBE), 32'(e.fb));
        check("stall_cycles", StallCycles, e.sc);
        check("flush_count", FlushCount, e.fc);
        check("timeout", 32'(MemTimeout), 32'(e.to));
        check("state", 32'(dut.state), 32'(e.st));
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
    endtask

    logic [31:0] s0;

    initial begin
        clear_inputs();
        m_reset();
        rst = 1'b1;
        #3;
        check("rst_stall_cycles", StallCycles, 32'd0);
        check("rst_flush_count", FlushCount, 32'd0);
        check("rst_timeout", 32'(MemTimeout), 32'd0);
        check("rst_state", 32'(dut.state), 32'd0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Forwarding: M beats W, W when M is x0, x0 never forwarded
        RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5;
        cycle();
        check("fwd_m_priority", 32'(ForwardAE), 32'd2);
        RdM = 0;
        cycle();
        check("fwd_w", 32'(ForwardAE), 32'd1);
        Rs2E = 0; RdW = 0;
        cycle();
        check("fwd_x0", 32'(ForwardBE), 32'd0);
        for (int i = 0; i < 24; i++) begin
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            cycle();
        end
        clear_inputs();

        // Load-use stalls one cycle, then clears
        MemReadE = 1; RdE = 7; Rs2D = 7;
        cycle();
        check("lu_stall_cycles", StallCycles, 32'd1);
        MemReadE = 0;
        cycle();
        check("lu_released", 32'(StallF), 32'd0);

        // Branch wins over simultaneous load-use
        PCSrcE = 1; MemReadE = 1; RdE = 3; Rs1D = 3;
        cycle();
        check("br_flush_count", FlushCount, 32'd1);
        clear_inputs();
        cycle();

        // Memory wait with a branch held pending throughout
        s0 = m_stall;
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        repeat (4) cycle();
        check("mw_state_wait", 32'(dut.state), 32'd1);
        check("mw_stall_cycles", StallCycles, s0 + 32'd4);
        MemReadyM = 1;
        cycle();
        clear_inputs();
        cycle();

        // Watchdog: ten wait cycles trip the sticky timeout
        MemReqM = 1; MemReadyM = 0;
        repeat (10) cycle();
        MemReadyM = 1;
        cycle();
        check("wd_set", 32'(MemTimeout), 32'd1);
        clear_inputs();
        repeat (3) cycle();
        check("wd_sticky", 32'(MemTimeout), 32'd1);

        // Asynchronous reset in the middle of a wait
        MemReqM = 1; MemReadyM = 0;
        repeat (3) cycle();
        #2 rst = 1'b1;
        #1;
        check("arst_stall_cycles", StallCycles, 32'd0);
        check("arst_flush_count", FlushCount, 32'd0);
        check("arst_timeout", 32'(MemTimeout), 32'd0);
        check("arst_state", 32'(dut.state), 32'd0);
        check("arst_comb_stall", 32'(StallF), 32'd1);
        m_reset();
        #1 rst = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
